// File: rtl/hgei_ctrl_if.sv
// Guest external interrupt bundle between the interrupt files / CSR file
// and the HGEI producer. The slave modport is the hgei_ctrl view; the
// master modport is the CSR-file / environment view.
interface hgei_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int GEILEN = 8
);
  logic [GEILEN-1:0] GuestExtIntIn;
  logic [GEILEN-1:0] EdgeModeCfg;
  logic [XLEN-1:0]   HGEIE_REGW;
  logic [5:0]        VGEIN;
  logic              ClaimValidM;
  logic [5:0]        ClaimIdM;
  logic              ClaimReadyM;
  logic              ClaimAckM;
  logic              ClaimHitM;
  logic [XLEN-1:0]   HGEIP_REGW;
  logic              SGEIPM;
  logic              VSEIPM;

  modport slave (
    input  GuestExtIntIn, EdgeModeCfg, HGEIE_REGW, VGEIN, ClaimValidM, ClaimIdM,
    output ClaimReadyM, ClaimAckM, ClaimHitM, HGEIP_REGW, SGEIPM, VSEIPM
  );

  modport master (
    output GuestExtIntIn, EdgeModeCfg, HGEIE_REGW, VGEIN, ClaimValidM, ClaimIdM,
    input  ClaimReadyM, ClaimAckM, ClaimHitM, HGEIP_REGW, SGEIPM, VSEIPM
  );
endinterface

// File: rtl/hgei_ctrl.sv
// Hypervisor guest-external-interrupt producer.
// Synchronizes per-guest interrupt lines, keeps a pending bit per guest
// (level-following or sticky edge), drives HGEIP and the SGEIP/VSEIP
// summary bits, and clears sticky bits through a two-state claim FSM.
//
// Only the XLEN field of the core configuration matters here, so it is
// taken directly as an integer parameter.
//
// Claim FSM:
//   state | meaning
//   IDLE  | ready for a claim; captures id and pending bit on ClaimValidM
//   ACK   | one-cycle ack pulse; clears the captured edge-mode bit
module hgei_ctrl #(
  parameter int XLEN        = 64,
  parameter int GEILEN      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       reset,
  hgei_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  // Synchronizer chain, stage 0 samples the raw lines.
  logic [SYNC_STAGES-1:0][GEILEN-1:0] sync_q, sync_d;
  logic [GEILEN-1:0] syncdly_q, syncdly_d;
  logic [GEILEN-1:0] sync, rise;

  logic [GEILEN-1:0] pend_q, pend_d;
  logic [GEILEN-1:0] clr;

  state_t     state_q, state_d;
  logic [5:0] id_q, id_d;
  logic       hit_q, hit_d;
  logic       req_hit;

  logic            claim_ready, claim_ack, claim_hit;
  logic [XLEN-1:0] hgeip;
  logic            sgeip, vseip;

  // Shift the raw lines one stage deeper each cycle; the last stage is
  // the synchronized value, delayed once more for edge detection.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.GuestExtIntIn};
    sync      = sync_q[SYNC_STAGES-1];
    syncdly_d = sync;
    rise      = sync & ~syncdly_q;
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      syncdly_q <= '0;
    end else begin
      sync_q    <= sync_d;
      syncdly_q <= syncdly_d;
    end
  end

  // Edge lines are sticky and a rise beats a same-cycle clear; level
  // lines simply follow the synchronized input.
  always_comb begin
    pend_d = (bus.EdgeModeCfg & (rise | (pend_q & ~clr)))
           | (~bus.EdgeModeCfg & sync);
  end

  // Pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // Pending bit of the guest currently being requested (0 if out of range).
  always_comb begin
    req_hit = 1'b0;
    for (int i = 1; i <= GEILEN; i++) begin
      if (bus.ClaimIdM == 6'(i)) req_hit = pend_q[i-1];
    end
  end

  // Clear strobe for the captured guest, only for edge-mode lines.
  always_comb begin
    clr = '0;
    if (state_q == ACK) begin
      for (int i = 1; i <= GEILEN; i++) begin
        if (id_q == 6'(i)) clr[i-1] = bus.EdgeModeCfg[i-1];
      end
    end
  end

  // Claim FSM next state and outputs.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    hit_d       = hit_q;
    claim_ready = 1'b0;
    claim_ack   = 1'b0;
    claim_hit   = 1'b0;
    case (state_q)
      IDLE: begin
        claim_ready = 1'b1;
        if (bus.ClaimValidM) begin
          id_d    = bus.ClaimIdM;
          hit_d   = req_hit;
          state_d = ACK;
        end
      end
      ACK: begin
        claim_ack = 1'b1;
        claim_hit = hit_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Claim FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      hit_q   <= hit_d;
    end
  end

  // HGEIP layout: bit 0 and bits above GEILEN are always zero; summaries
  // are combinational so they add no latency beyond the pending flops.
  always_comb begin
    hgeip             = '0;
    hgeip[GEILEN:1]   = pend_q;
    sgeip             = |(hgeip & bus.HGEIE_REGW);
    vseip             = 1'b0;
    for (int i = 1; i <= GEILEN; i++) begin
      if (bus.VGEIN == 6'(i)) vseip = pend_q[i-1];
    end
  end

  assign bus.HGEIP_REGW  = hgeip;
  assign bus.SGEIPM      = sgeip;
  assign bus.VSEIPM      = vseip;
  assign bus.ClaimReadyM = claim_ready;
  assign bus.ClaimAckM   = claim_ack;
  assign bus.ClaimHitM   = claim_hit;

endmodule

// File: tb/tb_hgei_ctrl.sv
// Self-checking bench for hgei_ctrl: level-mode vector table with a
// result scoreboard, plus hand sequences for latency, claims, races and
// reset during ACK.
module tb_hgei_ctrl;
  localparam int XLEN   = 64;
  localparam int GEILEN = 8;
  localparam int SYNC   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hgei_ctrl_if #(.XLEN(XLEN), .GEILEN(GEILEN)) bus ();

  hgei_ctrl #(.XLEN(XLEN), .GEILEN(GEILEN), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [GEILEN-1:0] lines;
    logic [XLEN-1:0]   hgeie;
    logic [5:0]        vgein;
    logic [XLEN-1:0]   hgeip;
    logic              sg;
    logic              vs;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0] hgeip;
    logic            sg;
    logic            vs;
  } exp_t;

  vec_t vecs[9];
  exp_t exp_q[$];
  logic hit_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int ack_total = 0;
  int ack_mark;

  always @(negedge clk) if (bus.ClaimAckM === 1'b1) ack_total++;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full claim of one id: request, ack cycle, return to idle.
  task automatic do_claim(input logic [5:0] id, input logic exp_hit);
    logic h;
    bus.ClaimValidM = 1'b1;
    bus.ClaimIdM    = id;
    #1;
    check("claim_ready", 64'(bus.ClaimReadyM), 64'd1);
    hit_q.push_back(exp_hit);
    tick(1);
    check("claim_ack", 64'(bus.ClaimAckM), 64'd1);
    check("claim_busy", 64'(bus.ClaimReadyM), 64'd0);
    h = hit_q.pop_front();
    check("claim_hit", 64'(bus.ClaimHitM), 64'(h));
    bus.ClaimValidM = 1'b0;
    tick(1);
    check("ack_pulse_end", 64'(bus.ClaimAckM), 64'd0);
  endtask

  initial begin
    exp_t e;
    logic h;

    vecs[0] = '{8'h04, 64'h8,                   6'd3,  64'h8,   1'b1, 1'b1};
    vecs[1] = '{8'h04, 64'h8,                   6'd9,  64'h8,   1'b1, 1'b0};
    vecs[2] = '{8'h04, 64'h10,                  6'd0,  64'h8,   1'b0, 1'b0};
    vecs[3] = '{8'hFF, 64'h200,                 6'd8,  64'h1FE, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 64'hFFFF_FFFF_FFFF_FE01, 6'd1,  64'h1FE, 1'b0, 1'b1};
    vecs[5] = '{8'h81, 64'h100,                 6'd7,  64'h102, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 6'd8,  64'h0,   1'b0, 1'b0};
    vecs[7] = '{8'h80, 64'h100,                 6'd63, 64'h100, 1'b1, 1'b0};
    vecs[8] = '{8'h80, 64'h100,                 6'd8,  64'h100, 1'b1, 1'b1};

    reset             = 1'b1;
    bus.GuestExtIntIn = '0;
    bus.EdgeModeCfg   = '0;
    bus.HGEIE_REGW    = '0;
    bus.VGEIN         = '0;
    bus.ClaimValidM   = 1'b0;
    bus.ClaimIdM      = '0;
    tick(2);
    check("rst_ack", 64'(bus.ClaimAckM), 64'd0);
    check("rst_hit", 64'(bus.ClaimHitM), 64'd0);
    reset = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("idle_hgeip", bus.HGEIP_REGW, 64'd0);
      check("idle_sgeip", 64'(bus.SGEIPM), 64'd0);
      check("idle_vseip", 64'(bus.VSEIPM), 64'd0);
      check("idle_ready", 64'(bus.ClaimReadyM), 64'd1);
    end

    // Level line 3 assert/deassert latency and summary tracking.
    bus.HGEIE_REGW    = 64'h8;
    bus.VGEIN         = 6'd3;
    bus.GuestExtIntIn = 8'h04;
    tick(2);
    check("lvl_rise_early", bus.HGEIP_REGW, 64'h0);
    tick(1);
    check("lvl_rise", bus.HGEIP_REGW, 64'h8);
    check("lvl_sgeip", 64'(bus.SGEIPM), 64'd1);
    check("lvl_vseip", 64'(bus.VSEIPM), 64'd1);
    bus.VGEIN = 6'd9;
    #1;
    check("lvl_vseip_oob", 64'(bus.VSEIPM), 64'd0);
    bus.VGEIN = 6'd3;
    bus.GuestExtIntIn = 8'h00;
    tick(2);
    check("lvl_fall_early", bus.HGEIP_REGW, 64'h8);
    tick(1);
    check("lvl_fall", bus.HGEIP_REGW, 64'h0);
    check("lvl_fall_sgeip", 64'(bus.SGEIPM), 64'd0);
    check("lvl_fall_vseip", 64'(bus.VSEIPM), 64'd0);

    // Level-mode vector table through the result scoreboard.
    for (int v = 0; v < 9; v++) begin
      bus.GuestExtIntIn = vecs[v].lines;
      bus.HGEIE_REGW    = vecs[v].hgeie;
      bus.VGEIN         = vecs[v].vgein;
      exp_q.push_back('{vecs[v].hgeip, vecs[v].sg, vecs[v].vs});
      tick(SYNC + 2);
      e = exp_q.pop_front();
      check("vec_hgeip", bus.HGEIP_REGW, e.hgeip);
      check("vec_sgeip", 64'(bus.SGEIPM), 64'(e.sg));
      check("vec_vseip", 64'(bus.VSEIPM), 64'(e.vs));
    end
    bus.GuestExtIntIn = '0;
    bus.HGEIE_REGW    = '0;
    bus.VGEIN         = '0;
    tick(SYNC + 2);

    // Edge line 5: sticky, then cleared by claim; second claim misses.
    bus.EdgeModeCfg   = 8'h10;
    bus.GuestExtIntIn = 8'h10;
    tick(3);
    bus.GuestExtIntIn = 8'h00;
    tick(5);
    check("edge5_sticky", bus.HGEIP_REGW, 64'h20);
    do_claim(6'd5, 1'b1);
    check("edge5_cleared", bus.HGEIP_REGW, 64'h0);
    do_claim(6'd5, 1'b0);
    check("edge5_still_clear", bus.HGEIP_REGW, 64'h0);

    // Edge line 2: new rise coincides with its clear.
    bus.EdgeModeCfg   = 8'h12;
    bus.GuestExtIntIn = 8'h02;
    tick(3);
    bus.GuestExtIntIn = 8'h00;
    tick(4);
    check("edge2_set", bus.HGEIP_REGW, 64'h4);
    bus.GuestExtIntIn = 8'h02;
    tick(1);
    bus.ClaimValidM = 1'b1;
    bus.ClaimIdM    = 6'd2;
    #1;
    check("race_ready", 64'(bus.ClaimReadyM), 64'd1);
    hit_q.push_back(1'b1);
    tick(1);
    check("race_ack", 64'(bus.ClaimAckM), 64'd1);
    h = hit_q.pop_front();
    check("race_hit", 64'(bus.ClaimHitM), 64'(h));
    bus.ClaimValidM = 1'b0;
    tick(1);
    check("race_keep", bus.HGEIP_REGW, 64'h4);
    do_claim(6'd2, 1'b1);
    check("race_later_clear", bus.HGEIP_REGW, 64'h0);
    bus.GuestExtIntIn = 8'h00;
    tick(4);

    // Back-to-back claims: guest 1 level high, guest 2 edge pending.
    bus.GuestExtIntIn = 8'h02;
    tick(3);
    bus.GuestExtIntIn = 8'h01;
    tick(4);
    check("b2b_setup", bus.HGEIP_REGW, 64'h6);
    ack_mark = ack_total;
    bus.ClaimValidM = 1'b1;
    bus.ClaimIdM    = 6'd1;
    #1;
    check("b2b_ready0", 64'(bus.ClaimReadyM), 64'd1);
    hit_q.push_back(1'b1);
    tick(1);
    check("b2b_ready1", 64'(bus.ClaimReadyM), 64'd0);
    check("b2b_ack1", 64'(bus.ClaimAckM), 64'd1);
    h = hit_q.pop_front();
    check("b2b_hit1", 64'(bus.ClaimHitM), 64'(h));
    bus.ClaimIdM = 6'd2;
    tick(1);
    check("b2b_ready2", 64'(bus.ClaimReadyM), 64'd1);
    check("b2b_noack", 64'(bus.ClaimAckM), 64'd0);
    hit_q.push_back(1'b1);
    tick(1);
    check("b2b_ready3", 64'(bus.ClaimReadyM), 64'd0);
    check("b2b_ack2", 64'(bus.ClaimAckM), 64'd1);
    h = hit_q.pop_front();
    check("b2b_hit2", 64'(bus.ClaimHitM), 64'(h));
    bus.ClaimValidM = 1'b0;
    tick(1);
    check("b2b_end_ack", 64'(bus.ClaimAckM), 64'd0);
    check("b2b_end_ready", 64'(bus.ClaimReadyM), 64'd1);
    check("b2b_ack_count", 64'(ack_total - ack_mark), 64'd2);
    check("b2b_hgeip", bus.HGEIP_REGW, 64'h2);
    do_claim(6'd0, 1'b0);
    check("id0_unchanged", bus.HGEIP_REGW, 64'h2);
    do_claim(6'd9, 1'b0);
    check("id9_unchanged", bus.HGEIP_REGW, 64'h2);

    // Reset in the middle of ACK with guests 1 and 4 pending (level).
    bus.EdgeModeCfg   = 8'h00;
    bus.GuestExtIntIn = 8'h09;
    tick(4);
    check("rstack_setup", bus.HGEIP_REGW, 64'h12);
    bus.ClaimValidM = 1'b1;
    bus.ClaimIdM    = 6'd4;
    tick(1);
    ack_mark = ack_total;
    #1;
    reset = 1'b1;
    #1;
    check("rstack_ack", 64'(bus.ClaimAckM), 64'd0);
    check("rstack_hgeip", bus.HGEIP_REGW, 64'h0);
    check("rstack_ready", 64'(bus.ClaimReadyM), 64'd1);
    check("rstack_sgeip", 64'(bus.SGEIPM), 64'd0);
    bus.ClaimValidM = 1'b0;
    tick(2);
    check("rstack_hold", bus.HGEIP_REGW, 64'h0);
    reset = 1'b0;
    tick(2);
    check("rstack_early", bus.HGEIP_REGW, 64'h0);
    tick(1);
    check("rstack_return", bus.HGEIP_REGW, 64'h12);
    check("rstack_no_ack", 64'(ack_total - ack_mark), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
